// File: rtl/pwm_duty_controller.sv
// ---------------------------------------------------------------------------
// pwm_duty_controller
//
// Purpose:
//   Two pushbuttons step a target level up and down between 0 and 10. The
//   target is shown as a percentage on dutyCycle. A ramp FSM moves the duty
//   that the PWM actually applies (activeDuty) towards that target in 10 %
//   steps, at most one step per PWM period and only on a period boundary.
//   The PWM period is 100 phase ticks, and each tick is CLK_DIV system clocks.
//
// Parameters:
//   CLK_DIV   - system clocks per PWM phase tick (2..65535)
//   DEBOUNCE  - consecutive stable cycles before a switch change is accepted
//               (2..65535)
//
// Ports:
//   clk        in   system clock, all state updates on its rising edge
//   rst        in   asynchronous active-high reset
//   switch1    in   raw increment pushbutton, asynchronous, active-high
//   switch2    in   raw decrement pushbutton, asynchronous, active-high
//   enable     in   PWM output enable, synchronous
//   counter    out  target level, 0..10
//   dutyCycle  out  target duty in percent (counter * 10)
//   activeDuty out  duty currently applied to the PWM, in percent
//   busy       out  high while the ramp FSM is not idle
//   pwmOut     out  registered PWM waveform
// ---------------------------------------------------------------------------
module pwm_duty_controller #(
    parameter int CLK_DIV  = 500,
    parameter int DEBOUNCE = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       enable,
    output logic [3:0] counter,
    output logic [7:0] dutyCycle,
    output logic [7:0] activeDuty,
    output logic       busy,
    output logic       pwmOut
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [6:0]  PHASE_LAST = 7'd99;
    localparam logic [3:0]  LEVEL_MAX  = 4'd10;
    localparam logic [7:0]  DUTY_STEP  = 8'd10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } rampState_t;

    // -----------------------------------------------------------------------
    // Internal signals
    // -----------------------------------------------------------------------
    logic [1:0]       rawSwitch;
    logic [1:0]       syncA;
    logic [1:0]       syncB;
    logic [1:0]       syncFill;
    logic [1:0]       stable;
    logic [1:0]       stablePrev;
    logic [1:0]       armed;
    logic [1:0][15:0] debCount;
    logic [1:0][15:0] lowCount;
    logic [1:0]       pressEvent;
    logic             incEvent;
    logic             decEvent;

    logic [15:0]      prescaler;
    logic [6:0]       phase;
    logic             tick;
    logic             boundary;

    rampState_t       rampState;
    logic [7:0]       stepUp;
    logic [7:0]       stepDown;

    // Index 0 is the increment button, index 1 the decrement button, so the
    // conditioning logic below can treat both switches identically.
    assign rawSwitch = {switch2, switch1};

    // -----------------------------------------------------------------------
    // Two-flop synchronizers for both raw switches. syncFill records how many
    // clocks have passed since reset; once its upper bit is set, syncB holds a
    // genuinely sampled switch value rather than the reset value, which the
    // arming logic below relies on.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncA    <= '0;
            syncB    <= '0;
            syncFill <= '0;
        end else begin
            syncA    <= rawSwitch;
            syncB    <= syncA;
            syncFill <= {syncFill[0], 1'b1};
        end
    end

    // -----------------------------------------------------------------------
    // Debouncers and press arming, one lane per switch.
    //
    // The stable state only follows the synchronized value after DEBOUNCE
    // consecutive disagreeing cycles; any agreeing cycle restarts the count.
    //
    // A lane is only armed to generate press events after it has seen its
    // synchronized switch low for DEBOUNCE consecutive valid cycles since
    // reset. That way a button held through reset cannot produce a press
    // when reset is released; the user has to let go and press again.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable     <= '0;
            stablePrev <= '0;
            armed      <= '0;
            debCount   <= '0;
            lowCount   <= '0;
        end else begin
            stablePrev <= stable;
            for (int i = 0; i < 2; i++) begin
                if (syncB[i] != stable[i]) begin
                    if (debCount[i] == DEB_LAST) begin
                        stable[i]   <= syncB[i];
                        debCount[i] <= '0;
                    end else begin
                        debCount[i] <= debCount[i] + 16'd1;
                    end
                end else begin
                    debCount[i] <= '0;
                end

                if (!armed[i] && syncFill[1]) begin
                    if (syncB[i]) begin
                        lowCount[i] <= '0;
                    end else if (lowCount[i] == DEB_LAST) begin
                        armed[i] <= 1'b1;
                    end else begin
                        lowCount[i] <= lowCount[i] + 16'd1;
                    end
                end
            end
        end
    end

    // Press events are one-cycle pulses on a debounced 0->1 transition.
    assign pressEvent = stable & ~stablePrev & armed;
    assign incEvent   = pressEvent[0];
    assign decEvent   = pressEvent[1];

    // -----------------------------------------------------------------------
    // Target level counter. Saturates at both ends; simultaneous increment
    // and decrement cancel out.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (incEvent && !decEvent) begin
            if (counter < LEVEL_MAX) begin
                counter <= counter + 4'd1;
            end
        end else if (decEvent && !incEvent) begin
            if (counter != 4'd0) begin
                counter <= counter - 4'd1;
            end
        end
    end

    // counter * 10 as (counter * 8) + (counter * 2), zero-extended to 8 bits.
    assign dutyCycle = {1'b0, counter, 3'b000} + {3'b000, counter, 1'b0};

    // -----------------------------------------------------------------------
    // Prescaler and phase counter. Both are held at zero while the output is
    // disabled, so re-enabling always starts a fresh period at phase 0. A tick
    // at phase 99 marks the boundary between PWM periods.
    // -----------------------------------------------------------------------
    assign tick     = enable && (prescaler == DIV_LAST);
    assign boundary = tick && (phase == PHASE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            phase     <= '0;
        end else if (!enable) begin
            prescaler <= '0;
            phase     <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                if (phase == PHASE_LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 7'd1;
                end
            end else begin
                prescaler <= prescaler + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Ramp FSM. The direction is re-evaluated every cycle against the current
    // target, so a target that crosses activeDuty flips the ramp direction
    // directly. activeDuty only moves on a period boundary, which keeps each
    // period's duty constant even if the target changes mid-period. When a
    // step lands exactly on the target the FSM returns to IDLE on the same
    // edge, so busy drops together with the final step.
    // -----------------------------------------------------------------------
    assign stepUp   = activeDuty + DUTY_STEP;
    assign stepDown = activeDuty - DUTY_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rampState  <= IDLE;
            activeDuty <= '0;
        end else begin
            case (rampState)
                IDLE: begin
                    if (activeDuty < dutyCycle) begin
                        rampState <= RAMP_UP;
                    end else if (activeDuty > dutyCycle) begin
                        rampState <= RAMP_DOWN;
                    end
                end

                RAMP_UP: begin
                    if (activeDuty == dutyCycle) begin
                        rampState <= IDLE;
                    end else if (activeDuty > dutyCycle) begin
                        rampState <= RAMP_DOWN;
                    end else if (boundary) begin
                        activeDuty <= stepUp;
                        if (stepUp == dutyCycle) begin
                            rampState <= IDLE;
                        end
                    end
                end

                RAMP_DOWN: begin
                    if (activeDuty == dutyCycle) begin
                        rampState <= IDLE;
                    end else if (activeDuty < dutyCycle) begin
                        rampState <= RAMP_UP;
                    end else if (boundary) begin
                        activeDuty <= stepDown;
                        if (stepDown == dutyCycle) begin
                            rampState <= IDLE;
                        end
                    end
                end

                default: begin
                    rampState <= IDLE;
                end
            endcase
        end
    end

    assign busy = (rampState != IDLE);

    // -----------------------------------------------------------------------
    // PWM output register. High for the first activeDuty phases of each
    // period, which naturally gives a constant 0 at 0 % and a constant 1 at
    // 100 % since phase never exceeds 99.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwmOut <= 1'b0;
        end else begin
            pwmOut <= enable && ({1'b0, phase} < activeDuty);
        end
    end

endmodule
